// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared PLL types: phase-detector state encoding and counter width helper
package pll_pkg;

  typedef enum logic [1:0] {
    PFD_IDLE = 2'd0,
    PFD_LEAD = 2'd1,
    PFD_LAG  = 2'd2
  } pfd_state_t;

  localparam int PFD_MAXCNT_DEFAULT = 255;

  function automatic int cnt_width(input int maxcnt);
    return $clog2(maxcnt + 1);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - 2-FF synchroniser with previous-value flop and rising-edge detect
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/pfd_digital.sv
// rtl/pfd_digital.sv - sampled tri-state phase-frequency detector with signed per-comparison error
module pfd_digital
  import pll_pkg::*;
#(
  parameter  int MAXCNT   = PFD_MAXCNT_DEFAULT,
  parameter  int DEADBAND = 0,
  localparam int CW       = cnt_width(MAXCNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 ref_in,
  input  logic                 fb_in,
  output logic                 up,
  output logic                 dn,
  output logic                 err_valid,
  output logic signed [CW:0]   err_out,
  output logic                 slip
);

  localparam logic [CW-1:0] MAX_C = CW'(MAXCNT);
  localparam logic [CW-1:0] DB_C  = CW'(DEADBAND);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic ref_rise, fb_rise;

  edge_sync u_ref_sync (.clk(clk), .rst_n(rst_n), .sig(ref_in), .rise(ref_rise));
  edge_sync u_fb_sync  (.clk(clk), .rst_n(rst_n), .sig(fb_in),  .rise(fb_rise));

  pfd_state_t       state, next_state;
  logic [CW-1:0]    cnt, next_cnt, cnt_inc;
  logic             close;
  logic signed [CW:0] close_err;

  assign cnt_inc = (cnt == MAX_C) ? cnt : cnt + ONE_C;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    close      = 1'b0;
    close_err  = '0;
    if (!en) begin
      next_state = PFD_IDLE;
      next_cnt   = '0;
    end else begin
      case (state)
        PFD_IDLE: begin
          if (ref_rise && fb_rise) begin
            close = 1'b1;
          end else if (ref_rise) begin
            next_state = PFD_LEAD;
            next_cnt   = ONE_C;
          end else if (fb_rise) begin
            next_state = PFD_LAG;
            next_cnt   = ONE_C;
          end
        end
        PFD_LEAD: begin
          if (fb_rise) begin
            close     = 1'b1;
            close_err = $signed({1'b0, cnt});
            // a coincident ref edge starts the next comparison straight away
            if (ref_rise) begin
              next_cnt = ONE_C;
            end else begin
              next_state = PFD_IDLE;
              next_cnt   = '0;
            end
          end else begin
            next_cnt = cnt_inc;
          end
        end
        PFD_LAG: begin
          if (ref_rise) begin
            close     = 1'b1;
            close_err = -$signed({1'b0, cnt});
            if (fb_rise) begin
              next_cnt = ONE_C;
            end else begin
              next_state = PFD_IDLE;
              next_cnt   = '0;
            end
          end else begin
            next_cnt = cnt_inc;
          end
        end
        default: begin
          next_state = PFD_IDLE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PFD_IDLE;
      cnt       <= '0;
      up        <= 1'b0;
      dn        <= 1'b0;
      slip      <= 1'b0;
      err_valid <= 1'b0;
      err_out   <= '0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      up        <= (next_state == PFD_LEAD) && (next_cnt > DB_C);
      dn        <= (next_state == PFD_LAG) && (next_cnt > DB_C);
      slip      <= (next_state != PFD_IDLE) && (next_cnt == MAX_C) && (cnt != MAX_C);
      err_valid <= close;
      if (close) begin
        err_out <= close_err;
      end
    end
  end

endmodule

// File: tb/tb_pfd_digital.sv
// tb/tb_pfd_digital.sv - randomized self-checking bench for pfd_digital against an event-level model
module tb_pfd_digital;

  localparam int MAXCNT = 15;
  localparam int CW     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic ref_in = 1'b0;
  logic fb_in = 1'b0;

  logic up0, dn0, ev0, slip0, up2, dn2, ev2, slip2;
  logic [CW:0] eo0, eo2;

  always #5 clk = ~clk;

  pfd_digital #(.MAXCNT(MAXCNT), .DEADBAND(0)) u_pfd0 (
    .clk(clk), .rst_n(rst_n), .en(en), .ref_in(ref_in), .fb_in(fb_in),
    .up(up0), .dn(dn0), .err_valid(ev0), .err_out(eo0), .slip(slip0)
  );

  pfd_digital #(.MAXCNT(MAXCNT), .DEADBAND(2)) u_pfd2 (
    .clk(clk), .rst_n(rst_n), .en(en), .ref_in(ref_in), .fb_in(fb_in),
    .up(up2), .dn(dn2), .err_valid(ev2), .err_out(eo2), .slip(slip2)
  );

  int n_checks = 0;
  int n_pass = 0;

  // reference: which input leads (+1/-1/0) and elapsed clk cycles of the open comparison
  int side, elapsed, m_eo;
  bit m_ev, m_slip;
  bit hr[4];
  bit hf[4];
  int up_hi0, dn_hi0, up_hi2, dn_hi2, slip_seen;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    side = 0; elapsed = 0; m_eo = 0; m_ev = 0; m_slip = 0;
    for (int i = 0; i < 4; i++) begin hr[i] = 0; hf[i] = 0; end
  endtask

  task automatic model_edge();
    bit rr, fr;
    int prev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 3; i > 0; i--) begin hr[i] = hr[i-1]; hf[i] = hf[i-1]; end
    hr[0] = ref_in;
    hf[0] = fb_in;
    rr = hr[2] && !hr[3];
    fr = hf[2] && !hf[3];
    prev = elapsed;
    m_ev = 0;
    m_slip = 0;
    if (!en) begin
      side = 0; elapsed = 0;
    end else if (side == 0) begin
      if (rr && fr) begin m_ev = 1; m_eo = 0; end
      else if (rr) begin side = 1; elapsed = 1; end
      else if (fr) begin side = -1; elapsed = 1; end
    end else begin
      bit closing, reopen;
      closing = (side == 1) ? fr : rr;
      reopen  = (side == 1) ? rr : fr;
      if (closing) begin
        m_ev = 1;
        m_eo = side * elapsed;
        if (reopen) elapsed = 1;
        else begin side = 0; elapsed = 0; end
      end else if (elapsed < MAXCNT) begin
        elapsed++;
      end
    end
    if (side != 0 && elapsed == MAXCNT && prev != MAXCNT) m_slip = 1;
  endtask

  task automatic compare();
    check("up0", int'(up0), int'(side == 1 && elapsed > 0));
    check("dn0", int'(dn0), int'(side == -1 && elapsed > 0));
    check("up2", int'(up2), int'(side == 1 && elapsed > 2));
    check("dn2", int'(dn2), int'(side == -1 && elapsed > 2));
    check("err_valid0", int'(ev0), int'(m_ev));
    check("err_valid2", int'(ev2), int'(m_ev));
    check("slip0", int'(slip0), int'(m_slip));
    check("slip2", int'(slip2), int'(m_slip));
    check("err_out0", int'($signed(eo0)), m_eo);
    check("err_out2", int'($signed(eo2)), m_eo);
    up_hi0 += int'(up0); dn_hi0 += int'(dn0);
    up_hi2 += int'(up2); dn_hi2 += int'(dn2);
    slip_seen += int'(slip0);
  endtask

  task automatic step(input bit r, input bit f, input bit e);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    ref_in = r;
    fb_in = f;
    en = e;
  endtask

  // single comparison: fb rises d cycles after ref (d<0: fb first)
  task automatic trial(input int d);
    int t_r, t_f, len, mag;
    t_r = (d >= 0) ? 0 : -d;
    t_f = (d >= 0) ? d : 0;
    mag = (d >= 0) ? d : -d;
    len = mag + 14;
    up_hi0 = 0; dn_hi0 = 0; up_hi2 = 0; dn_hi2 = 0;
    for (int i = 0; i < len; i++)
      step(i >= t_r && i < t_r + 3, i >= t_f && i < t_f + 3, 1'b1);
    check($sformatf("up_cycles0[%0d]", d), up_hi0, (d > 0) ? mag : 0);
    check($sformatf("dn_cycles0[%0d]", d), dn_hi0, (d < 0) ? mag : 0);
    check($sformatf("up_cycles2[%0d]", d), up_hi2, (d > 2) ? mag - 2 : 0);
    check($sformatf("dn_cycles2[%0d]", d), dn_hi2, (d < -2) ? mag - 2 : 0);
  endtask

  initial begin
    model_reset();
    up_hi0 = 0; dn_hi0 = 0; up_hi2 = 0; dn_hi2 = 0; slip_seen = 0;
    #1;
    check("rst_up", int'(up0), 0);
    check("rst_err_out", int'(eo0), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

    trial(5);
    trial(-3);
    trial(0);
    trial(2);
    trial(4);
    for (int k = 0; k < 20; k++) trial($urandom_range(0, 24) - 12);

    // fb silent while ref keeps toggling: counter saturates once
    slip_seen = 0;
    for (int i = 0; i < 60; i++) step((i % 4) < 2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
    check("slip_pulses", slip_seen, 1);
    check("slip_err_out", int'($signed(eo0)), MAXCNT);

    // free-running random edges with occasional enable drops
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 4) == 0 ? ~ref_in : ref_in,
           $urandom_range(0, 4) == 0 ? ~fb_in : fb_in,
           $urandom_range(0, 29) != 0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);

    // reset asserted in the middle of a lead comparison
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1);
    check("pre_rst_up", int'(up0), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_up", int'(up0), 0);
    check("async_rst_valid", int'(ev0), 0);
    check("async_rst_slip", int'(slip0), 0);
    check("async_rst_err_out", int'(eo0), 0);
    model_reset();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    trial(6);
    check("post_rst_err_out", int'($signed(eo0)), 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
